// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit start qualification, LSB-first shift, stop check.
// Define UART_RX_SYNC_EN to add a 2-flop input synchronizer on i_rx.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       busy
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;

    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sr;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    // Flops reset to the idle level so reset never looks like a start bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], i_rx};
        end
    end

    assign rx_s = sync[1];
`else
    assign rx_s = i_rx;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            sr          <= '0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        sr  <= {rx_s, sr[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        o_data <= sr;
                        if (rx_s) begin
                            o_valid <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= RECOVER;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A held-low line parks here so a break reports only once
                RECOVER: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed and random frames against a timing model
// that predicts each pulse's edge number from the frame start edge.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (ferr),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  nvec = 0;
    int  nerr = 0;
    int  cyc  = 0;
    int  busy_cnt = 0;
    int  last_busy = -1;
    ev_t vq[$];
    ev_t eq[$];
    int  fq[$];
    int  efq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the line, take the edge, sample outputs 1ns later
    task automatic tick(input logic v);
        ev_t e;
        rx = v;
        @(posedge clk);
        cyc++;
        #1;
        if (valid === 1'b1) begin
            e.cyc = cyc;
            e.d   = data;
            vq.push_back(e);
        end
        if (ferr === 1'b1) fq.push_back(cyc);
        if (busy === 1'b1) begin
            busy_cnt++;
            last_busy = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    // The edge that first sees the start bit is the next one; the stop bit
    // is judged HALF + 9 bit-times later, plus any synchronizer delay.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        int  t;
        ev_t e;
        t = cyc + 1;
        for (int i = 0; i < CPB; i++) tick(1'b0);
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < CPB; i++) tick(b[k]);
        for (int i = 0; i < CPB; i++) tick(stop);
        if (stop) begin
            e.cyc = t + HALF + 9 * CPB + LAT;
            e.d   = b;
            eq.push_back(e);
        end else begin
            efq.push_back(t + HALF + 9 * CPB + LAT);
        end
    endtask

    task automatic check_pulses(input string tag);
        int n;
        chk({tag, "_nvalid"}, vq.size(), eq.size());
        n = (vq.size() < eq.size()) ? vq.size() : eq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_vcyc"}, vq[i].cyc, eq[i].cyc);
            chk({tag, "_vdata"}, {24'd0, vq[i].d}, {24'd0, eq[i].d});
        end
        chk({tag, "_nferr"}, fq.size(), efq.size());
        n = (fq.size() < efq.size()) ? fq.size() : efq.size();
        for (int i = 0; i < n; i++) chk({tag, "_fcyc"}, fq[i], efq[i]);
        vq.delete();
        eq.delete();
        fq.delete();
        efq.delete();
    endtask

    initial begin
        int          h;
        logic [7:0]  b;
        logic [7:0]  c3;

        rst = 1'b1;
        rx  = 1'b1;
        tick(1'b1);
        tick(1'b1);
        chk("rst_data", {24'd0, data}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_ferr", {31'd0, ferr}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 1'b1);
        idle(20);
        check_pulses("single");
        chk("single_data", {24'd0, data}, 32'hA5);
        chk("single_busy", {31'd0, busy}, 32'h0);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(20);
        chk("b2b_gap1", eq[1].cyc - eq[0].cyc, 32'd160);
        check_pulses("b2b");

        busy_cnt = 0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        idle(30);
        chk("glitch_busy", busy_cnt, 32'd8);
        check_pulses("glitch");
        chk("glitch_data", {24'd0, data}, 32'h3C);

        send_frame(8'h55, 1'b0);
        for (int i = 0; i < 100; i++) tick(1'b0);
        h = cyc + 1;
        idle(20);
        check_pulses("ferr");
        chk("ferr_data", {24'd0, data}, 32'h55);
        chk("ferr_busy_end", last_busy, h + LAT - 1);
        send_frame(8'h12, 1'b1);
        idle(20);
        check_pulses("after_ferr");

        c3 = 8'hC3;
        for (int i = 0; i < CPB; i++) tick(1'b0);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < CPB; i++) tick(c3[k]);
        for (int i = 0; i < HALF; i++) tick(c3[4]);
        rst = 1'b1;
        tick(c3[4]);
        rst = 1'b0;
        chk("mrst_data", {24'd0, data}, 32'h0);
        chk("mrst_valid", {31'd0, valid}, 32'h0);
        chk("mrst_ferr", {31'd0, ferr}, 32'h0);
        chk("mrst_busy", {31'd0, busy}, 32'h0);
        idle(40);
        check_pulses("mrst_abort");
        send_frame(8'h7E, 1'b1);
        idle(20);
        check_pulses("mrst_next");
        chk("mrst_next_data", {24'd0, data}, 32'h7E);

        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            idle($urandom_range(0, 5));
        end
        idle(20);
        check_pulses("random");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
